// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and constants for the BIST pattern sequencer
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        APPLY,
        CAPTURE,
        COMPARE,
        DONE
    } bist_state_e;

    localparam logic [7:0] DEFAULT_TAPS = 8'hB8;
    localparam int         SEED_MAX_W   = 64;

    // An all-zero LFSR state would lock up, so zero is promoted to 1.
    function automatic logic [SEED_MAX_W-1:0] nonzero_seed(input logic [SEED_MAX_W-1:0] seed);
        return (seed == '0) ? SEED_MAX_W'(1) : seed;
    endfunction

endpackage

// File: rtl/bist_if.sv
// rtl/bist_if.sv - run control, CUT and status signals of the BIST sequencer (abort under BIST_ABORT_EN)
interface bist_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] golden_sig;
    logic [WIDTH-1:0] cut_resp;
    logic             gen_bit;
    logic             pattern_strobe;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;
`ifdef BIST_ABORT_EN
    logic             abort;

    modport master (
        output start, golden_sig, cut_resp, abort,
        input  gen_bit, pattern_strobe, busy, done, pass, signature
    );
    modport slave (
        input  start, golden_sig, cut_resp, abort,
        output gen_bit, pattern_strobe, busy, done, pass, signature
    );
`else
    modport master (
        output start, golden_sig, cut_resp,
        input  gen_bit, pattern_strobe, busy, done, pass, signature
    );
    modport slave (
        input  start, golden_sig, cut_resp,
        output gen_bit, pattern_strobe, busy, done, pass, signature
    );
`endif
endinterface

// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - multiple-input signature register compacting CUT responses
module bist_misr
    import bist_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (enable) begin
            sig <= ({sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? TAPS : '0)) ^ din;
        end
    end

endmodule

// File: rtl/bist_controller.sv
// rtl/bist_controller.sv - BIST sequencer: LFSR pattern stream, CUT strobe, MISR compare
// Optional run abort input enabled by macro BIST_ABORT_EN.
module bist_controller
    import bist_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               NUM_PATTERNS = 16,
    parameter logic [WIDTH-1:0] SEED         = WIDTH'(8'hA5),
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(DEFAULT_TAPS)
) (
    input logic  clk,
    input logic  rst_n,
    bist_if.slave bus
);

    localparam int               BIT_W    = $clog2(WIDTH);
    localparam int               PAT_W    = $clog2(NUM_PATTERNS + 1);
    localparam logic [WIDTH-1:0] SEED_NZ  = WIDTH'(nonzero_seed(SEED_MAX_W'(SEED)));
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [PAT_W-1:0] LAST_PAT = PAT_W'(NUM_PATTERNS - 1);

    bist_state_e      state, state_nxt;
    logic [WIDTH-1:0] lfsr, lfsr_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [PAT_W-1:0] pat_cnt, pat_cnt_nxt;
    logic             gen_bit_q, strobe_q, busy_q, done_q, pass_q, pass_nxt;
    logic             misr_clear, misr_en, abort_hit;
    logic [WIDTH-1:0] misr_sig;

    bist_misr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (misr_clear),
        .enable (misr_en),
        .din    (bus.cut_resp),
        .sig    (misr_sig)
    );

    always_comb begin
        state_nxt   = state;
        lfsr_nxt    = lfsr;
        bit_cnt_nxt = bit_cnt;
        pat_cnt_nxt = pat_cnt;
        pass_nxt    = pass_q;
        misr_clear  = 1'b0;
        misr_en     = 1'b0;
        abort_hit   = 1'b0;
`ifdef BIST_ABORT_EN
        abort_hit   = bus.abort && (state inside {SHIFT, APPLY, CAPTURE, COMPARE});
`endif

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt   = SHIFT;
                    lfsr_nxt    = SEED_NZ;
                    bit_cnt_nxt = '0;
                    pat_cnt_nxt = '0;
                    pass_nxt    = 1'b0;
                    misr_clear  = 1'b1;
                end
            end
            SHIFT: begin
                lfsr_nxt = {^(lfsr & TAPS), lfsr[WIDTH-1:1]};
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt_nxt = '0;
                    state_nxt   = APPLY;
                end else begin
                    bit_cnt_nxt = bit_cnt + BIT_W'(1);
                end
            end
            APPLY: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                misr_en     = 1'b1;
                pat_cnt_nxt = pat_cnt + PAT_W'(1);
                state_nxt   = (pat_cnt == LAST_PAT) ? COMPARE : SHIFT;
            end
            COMPARE: begin
                pass_nxt  = (misr_sig == bus.golden_sig);
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort overrides whatever the busy state would have done this cycle.
        if (abort_hit) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            pat_cnt_nxt = '0;
            pass_nxt    = 1'b0;
            misr_clear  = 1'b1;
            misr_en     = 1'b0;
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= SEED_NZ;
            bit_cnt   <= '0;
            pat_cnt   <= '0;
            gen_bit_q <= 1'b0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            bit_cnt   <= bit_cnt_nxt;
            pat_cnt   <= pat_cnt_nxt;
            gen_bit_q <= (state_nxt == SHIFT) && lfsr_nxt[0];
            strobe_q  <= (state_nxt == APPLY);
            busy_q    <= (state_nxt inside {SHIFT, APPLY, CAPTURE, COMPARE});
            done_q    <= (state_nxt == DONE);
            pass_q    <= pass_nxt;
        end
    end

    assign bus.gen_bit        = gen_bit_q;
    assign bus.pattern_strobe = strobe_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.signature      = misr_sig;

endmodule

// File: tb/tb_bist_controller.sv
// tb/tb_bist_controller.sv - self-checking bench for bist_controller (one- and two-pattern instances)
module tb_bist_controller;

    localparam int         W     = 8;
    localparam logic [7:0] SEED  = 8'hA5;
    localparam logic [7:0] TAPS  = 8'hB8;
    localparam int         PER   = W + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bist_if #(.WIDTH(W)) b1 ();
    bist_if #(.WIDTH(W)) b2 ();

    bist_controller #(.WIDTH(W), .NUM_PATTERNS(1), .SEED(SEED), .TAPS(TAPS)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (b1)
    );
    bist_controller #(.WIDTH(W), .NUM_PATTERNS(2), .SEED(SEED), .TAPS(TAPS)) dut2 (
        .clk (clk), .rst_n (rst_n), .bus (b2)
    );

    int         sel = 1;
    logic       start_d = 1'b0;
    logic       abort_d = 1'b0;
    logic [7:0] cut_d = 8'h00;
    logic [7:0] gold_d = 8'h00;
    logic       o_gen, o_stb, o_busy, o_done, o_pass;
    logic [7:0] o_sig;

    always_comb begin
        b1.start      = (sel == 1) && start_d;
        b2.start      = (sel == 2) && start_d;
        b1.cut_resp   = cut_d;
        b2.cut_resp   = cut_d;
        b1.golden_sig = gold_d;
        b2.golden_sig = gold_d;
`ifdef BIST_ABORT_EN
        b1.abort      = (sel == 1) && abort_d;
        b2.abort      = (sel == 2) && abort_d;
`endif
    end

    always_comb begin
        if (sel == 2) begin
            o_gen = b2.gen_bit; o_stb = b2.pattern_strobe; o_busy = b2.busy;
            o_done = b2.done; o_pass = b2.pass; o_sig = b2.signature;
        end else begin
            o_gen = b1.gen_bit; o_stb = b1.pattern_strobe; o_busy = b1.busy;
            o_done = b1.done; o_pass = b1.pass; o_sig = b1.signature;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit stream as a linear recurrence: b[n+W] = XOR of b[n+i] over the tap positions.
    logic stream [0:63];
    initial begin
        for (int i = 0; i < W; i++) stream[i] = SEED[i];
        for (int n = 0; n + W < 64; n++) begin
            logic x;
            x = 1'b0;
            for (int i = 0; i < W; i++) if (TAPS[i]) x ^= stream[n + i];
            stream[n + W] = x;
        end
    end

    // Multiplication by x modulo the feedback polynomial.
    function automatic logic [7:0] mulx(input logic [7:0] v);
        return v[7] ? ((v << 1) ^ TAPS) : (v << 1);
    endfunction

    // Signature as a linear sum: response j is weighted by x^(n-1-j).
    function automatic logic [7:0] sig_model(input logic [7:0] r0, input logic [7:0] r1, input int n);
        logic [7:0] t0, t1;
        t0 = r0;
        if (n == 1) return t0;
        t0 = mulx(t0);
        t1 = r1;
        return t0 ^ t1;
    endfunction

    // One run on the selected instance; checks stream/strobe timing against the cycle plan.
    task automatic run(input int n_pat, input logic [7:0] r0, input logic [7:0] r1,
                       input logic [7:0] gold, input int mid_start_at, input int abort_at,
                       output int done_cyc);
        int c, pi, ph, errs, limit;
        logic exp_gen, exp_stb, in_run;
        logic [7:0] resp [2];
        resp[0] = r0;
        resp[1] = r1;
        c = 0;
        errs = 0;
        done_cyc = -1;
        limit = n_pat * PER + 40;
        sel = n_pat;
        @(negedge clk);
        start_d = 1'b1;
        gold_d  = 8'($urandom);
        cut_d   = 8'($urandom);
        while (c < limit && done_cyc < 0) begin
            @(negedge clk);
            c++;
            pi = (c - 1) / PER;
            ph = (c - 1) % PER;
            in_run  = (pi < n_pat);
            exp_gen = (in_run && ph < W) ? stream[pi * W + ph] : 1'b0;
            exp_stb = in_run && (ph == W);
            if (abort_at == 0 || c <= abort_at) begin
                if (o_gen !== exp_gen || o_stb !== exp_stb) errs++;
                if (o_busy !== (in_run || c == n_pat * PER + 1)) errs++;
            end
            if (abort_at > 0 && c == abort_at + 1 && (o_busy !== 1'b0 || o_sig !== 8'h00)) errs++;
            if (c == 1 && (o_done !== 1'b0 || o_sig !== 8'h00 || o_pass !== 1'b0)) errs++;
            if (o_done === 1'b1) done_cyc = c;
            start_d = (c == mid_start_at);
            abort_d = (abort_at > 0 && c == abort_at);
            cut_d   = (in_run && ph == W + 1) ? resp[pi] : 8'($urandom);
            gold_d  = (c == n_pat * PER + 1) ? gold : 8'($urandom);
        end
        start_d = 1'b0;
        abort_d = 1'b0;
        check("stream_timing", errs, 0);
    endtask

    typedef struct {
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] gold;
        logic [7:0] sig;
        logic       pass;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int dc, n, seen, mid;
        logic [7:0] r0, r1, g, e;

        tbl[0] = '{8'h01, 8'h00, 8'h02, 8'h02, 1'b1};
        tbl[1] = '{8'h01, 8'h00, 8'h03, 8'h02, 1'b0};
        tbl[2] = '{8'h80, 8'h00, 8'hB8, 8'hB8, 1'b1};
        tbl[3] = '{8'h80, 8'h00, 8'h00, 8'hB8, 1'b0};
        tbl[4] = '{8'hFF, 8'hFF, 8'hB9, 8'hB9, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b1};

        // Reset held with start asserted.
        sel = 1;
        start_d = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy1", b1.busy, 0);
        check("rst_done1", b1.done, 0);
        check("rst_pass1", b1.pass, 0);
        check("rst_gen1", b1.gen_bit, 0);
        check("rst_strobe1", b1.pattern_strobe, 0);
        check("rst_sig1", b1.signature, 0);
        check("rst_busy2", b2.busy, 0);
        check("rst_sig2", b2.signature, 0);
        start_d = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", b1.busy | b2.busy, 0);
        check("idle_done", b1.done | b2.done, 0);
        check("idle_gen", b1.gen_bit | b1.pattern_strobe, 0);

        // Single-pattern run: A5 stream, strobe, done after 12 cycles.
        run(1, 8'h3C, 8'h00, 8'h3C, 0, 0, dc);
        check("n1_done_cyc", dc, 12);
        check("n1_sig", o_sig, 8'h3C);
        check("n1_pass", o_pass, 1);
        check("n1_busy_at_done", o_busy, 0);
        run(1, 8'h5A, 8'h00, 8'h00, 4, 0, dc);
        check("n1_midstart_done_cyc", dc, 12);
        check("n1_midstart_pass", o_pass, 0);

        // Two-pattern signature table; each run restarts from DONE.
        for (int i = 0; i < 6; i++) begin
            run(2, tbl[i].r0, tbl[i].r1, tbl[i].gold, (i == 1) ? 7 : 0, 0, dc);
            check($sformatf("tbl%0d_done_cyc", i), dc, 2 * PER + 2);
            check($sformatf("tbl%0d_sig", i), o_sig, tbl[i].sig);
            check($sformatf("tbl%0d_pass", i), o_pass, tbl[i].pass);
        end

        // Randomised runs against the reference model.
        for (int k = 0; k < 20; k++) begin
            n  = $urandom_range(1, 2);
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            e  = sig_model(r0, r1, n);
            g  = ($urandom_range(0, 1) == 1) ? e : (e ^ 8'($urandom_range(1, 255)));
            mid = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n * PER + 1) : 0;
            run(n, r0, r1, g, mid, 0, dc);
            check($sformatf("rnd%0d_done_cyc", k), dc, n * PER + 2);
            check($sformatf("rnd%0d_sig", k), o_sig, e);
            check($sformatf("rnd%0d_pass", k), o_pass, (g == e));
        end

`ifdef BIST_ABORT_EN
        // Abort during the first CAPTURE: no result ever appears.
        run(2, 8'h11, 8'h22, 8'h00, 0, PER, dc);
        check("abort_no_done", dc, -1);
        check("abort_sig", o_sig, 0);
        check("abort_pass", o_pass, 0);
`endif

        // Reset pulsed while the pattern is being applied.
        sel = 1;
        seen = 0;
        @(negedge clk);
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            if (o_stb === 1'b1) seen = 1;
            else @(negedge clk);
        end
        check("apply_seen", seen, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_strobe", o_stb, 0);
        check("rst_mid_busy", o_busy, 0);
        check("rst_mid_sig", o_sig, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (o_done === 1'b1 || o_busy === 1'b1) seen++;
        end
        check("rst_mid_no_activity", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
